// File: rtl/de0_led_slider_scan.sv
// LED bar / two-digit 7-segment position display with manual slider and bouncing auto-scan modes.
// Define LED_SLIDER_LZB_EN to blank the tens digit while the position is below 10.
module de0_led_slider_scan #(
  parameter int N_LED    = 8,
  parameter int DIN_W    = 4,
  parameter int TICK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [DIN_W-1:0] din,
  output logic [N_LED-1:0] dout,
  output logic [6:0]       fnd_30_out,
  output logic [6:0]       fnd_74_out
);

  localparam int POS_W = $clog2(N_LED);
  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LED - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_LED-1:0] dout_q, dout_d;
  logic [6:0]       fnd_30_q, fnd_30_d;
  logic [6:0]       fnd_74_q, fnd_74_d;

  logic             scan_mode;
  logic             bar_mode;
  logic             tick;
  logic [31:0]      din_ext;
  logic [31:0]      pos_ext;
  logic [3:0]       ones_digit;
  logic [3:0]       tens_digit;

  assign scan_mode = mode[1];
  assign bar_mode  = mode[0];
  assign din_ext   = 32'(din);
  assign pos_ext   = 32'(pos_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q    <= '0;
      dir_q    <= DIR_UP;
      cnt_q    <= '0;
      dout_q   <= '0;
      fnd_30_q <= SEG_BLANK;
      fnd_74_q <= SEG_BLANK;
    end else begin
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      fnd_30_q <= fnd_30_d;
      fnd_74_q <= fnd_74_d;
    end
  end

  // Position / direction / prescaler update.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!scan_mode) begin
      cnt_d = '0;
      pos_d = (din_ext > 32'(N_LED - 1)) ? POS_MAX : din_ext[POS_W-1:0];
    end else begin
      tick  = (cnt_q == CNT_MAX);
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      if (tick) begin
        // Ends reverse immediately: the end LED is shown for one step only.
        if (dir_q == DIR_UP) begin
          if (pos_q != POS_MAX) begin
            pos_d = pos_q + POS_W'(1);
          end else begin
            pos_d = pos_q - POS_W'(1);
            dir_d = DIR_DOWN;
          end
        end else begin
          if (pos_q != '0) begin
            pos_d = pos_q - POS_W'(1);
          end else begin
            pos_d = pos_q + POS_W'(1);
            dir_d = DIR_UP;
          end
        end
      end
    end
  end

  // Output stage decodes the current position; registered, so it trails pos by one clock.
  always_comb begin
    dout_d = '0;
    for (int i = 0; i < N_LED; i++) begin
      dout_d[i] = bar_mode ? (32'(i) <= pos_ext) : (32'(i) == pos_ext);
    end
    ones_digit = 4'(pos_ext % 32'd10);
    tens_digit = 4'(pos_ext / 32'd10);
    fnd_30_d   = seg7(ones_digit);
    fnd_74_d   = seg7(tens_digit);
`ifdef LED_SLIDER_LZB_EN
    if (pos_ext < 32'd10) begin
      fnd_74_d = SEG_BLANK;
    end
`else
    fnd_74_d = seg7(tens_digit);
`endif
  end

  assign dout       = dout_q;
  assign fnd_30_out = fnd_30_q;
  assign fnd_74_out = fnd_74_q;

endmodule

// File: doc/de0_led_slider_scan.md
Name: de0_led_slider_scan

Overview:
Parametrised successor to the DE0 LED slider.
- Drives an N_LED-wide LED bar and two 7-segment digits that show the current bar position in decimal.
- Adds a sequential auto-scan (bounce) mode with a programmable prescaler, alongside the manual slider modes.
- All outputs are registered. Sits between the board switches/board clock and the LED/FND pins.

Parameters:
- N_LED, 8, number of LEDs; legal range 2..64.
- DIN_W, 4, width of the manual position input din.
- TICK_DIV, 25000000, clocks per scan step; must be ≥ 2. The bench uses 4.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  00 manual dot, 01 manual bar, 10 scan dot, 11 scan bar.
- din  input  DIN_W  manual position; unsigned.
- dout  output  N_LED  LED drive, active-high, bit 0 = leftmost position 0.
- fnd_30_out  output  7  ones digit of pos; segments {g,f,e,d,c,b,a}, active-low.
- fnd_74_out  output  7  tens digit of pos; same encoding.

Behaviour:
- State registers:
  - pos: range 0..N_LED-1, width clog2(N_LED).
  - dir: 0 = up, 1 = down.
  - prescaler cnt: range 0..TICK_DIV-1.
- Reset (async assert, sync release):
  - pos = 0, dir = up, cnt = 0.
  - dout = 0.
  - fnd_30_out = 7'h7F (blank), fnd_74_out = 7'h7F.
- Manual modes (mode[1] = 0):
  - Every clock, pos <= min(din, N_LED-1). Clamp is required when din ≥ N_LED.
  - cnt is held at 0.
  - dir is left unchanged.
- Scan modes (mode[1] = 1):
  - cnt increments each clock. tick = (cnt == TICK_DIV-1), and cnt then wraps to 0.
  - On tick with dir = up:
    - if pos < N_LED-1: pos + 1.
    - else: pos - 1 and dir <= down (bounce, no dwell at the end).
  - On tick with dir = down:
    - if pos > 0: pos - 1.
    - else: pos + 1 and dir <= up.
  - Without a tick, pos holds.
- Mode entry:
  - Manual→scan: the scan starts from the current pos with the current dir. The first step occurs TICK_DIV clocks after entry, because cnt starts at 0.
  - Scan→manual: cnt clears on the next clock; pos follows din.
  - Switching between 10 and 11 does not disturb pos, dir or cnt.
- Output stage: one register, so outputs lag pos by exactly 1 clock.
  - mode[0] = 0 (dot): dout = one-hot, only bit pos set.
  - mode[0] = 1 (bar): dout bits [pos:0] set, others 0. pos = 0 lights one LED.
  - fnd_30_out = seg(pos % 10); fnd_74_out = seg(pos / 10). pos ≤ 63, so tens ≤ 6.
  - seg table (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- Reset asserted mid-scan returns every register to its reset value immediately. Outputs update on the first clock after release.
- din and mode are synchronous to clk. Synchronisation of the raw board switches is external to this block.

Optional Feature:
- LED_SLIDER_LZB_EN.
  - Defined: leading-zero blanking. When pos < 10, fnd_74_out = 7'h7F (blank).
  - Undefined: the tens digit always shows, so pos < 10 gives fnd_74_out = 7'h40 ("0").
- The ones digit is unaffected either way.

Test Plan:
- Reset check: hold rst_n = 0 with mode = 00, din = 5 → dout = 00, both FND = 7F. Release, then 2 clocks later → dout = 8'h20, fnd_30 = 12, fnd_74 = 40 (7F with LZB).
- Manual bar and clamp: mode = 01, din = 3 → dout = 8'h0F. Then din = 15 (N_LED = 8) → pos clamps to 7, dout = FF, fnd_30 = 78.
- Scan dot bounce: TICK_DIV = 4, mode = 00 with din = 0, then mode = 10 → pos steps every 4 clocks: 0,1,…,7,6,…,0,1. dout goes 01,02,…,80,40,…; no repeat of 80 or 01 at the ends.
- Scan bar: mode = 11 from pos = 6, dir up → dout = 7F, FF, 7F, 3F on successive ticks.
- Mode switch mid-scan: in mode 10 at pos = 4 with dir down, go 10→00 with din = 2 → dout = 04 one clock after pos updates. Return to 10 → first step occurs 4 clocks later, from pos 2, going down.
- Wide instance: N_LED = 16, DIN_W = 5, mode = 00, din = 12 → dout = 16'h1000, fnd_74 = 79, fnd_30 = 24. Then async reset mid-operation → all outputs go to reset values within the same cycle.
